// File: rtl/imem_boot_loader.sv
// imem_boot_loader: streams instruction words into IMEM from address 0 while holding the core in reset.
// Optional feature: define LOADER_CHECKSUM_EN to add a running checksum output.
module imem_boot_loader #(
    parameter int WIDTH = 32,
    parameter int SIZE = 64,
    parameter int RESET_HOLD = 4,
    localparam int LOGSIZE = $clog2(SIZE)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [LOGSIZE:0]   num_words,
    input  logic [WIDTH-1:0]   s_data,
    input  logic               s_valid,
    output logic               s_ready,
    output logic [WIDTH-1:0]   instr_in,
    output logic [LOGSIZE+1:0] instr_wr_addr,
    output logic               instr_wr_en,
    output logic               core_reset,
    output logic               busy,
    output logic               done,
    output logic               error
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [WIDTH-1:0]   checksum
`endif
);
    localparam int NW = LOGSIZE + 1;
    localparam int HW = $clog2(RESET_HOLD + 1);
    typedef enum logic [1:0] {IDLE, LOAD, RELEASE, RUN} state_t;
    state_t             state_q, state_d;
    logic [NW-1:0]      count_q, count_d, num_q, num_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic               error_q, error_d, done_q, done_d, wr_en_q, wr_en_d;
    logic [WIDTH-1:0]   wr_data_q, wr_data_d;
    logic [LOGSIZE+1:0] wr_addr_q, wr_addr_d;
    logic               legal, fire, can_start;
`ifdef LOADER_CHECKSUM_EN
    logic [WIDTH-1:0]   sum_q, sum_d;
    assign checksum = sum_q;
`endif
    assign legal         = (num_words != '0) && (num_words <= NW'(SIZE));
    assign can_start     = start && (state_q == IDLE || state_q == RUN);
    assign fire          = s_valid && (state_q == LOAD);
    assign s_ready       = state_q == LOAD;
    assign busy          = state_q == LOAD || state_q == RELEASE;
    assign core_reset    = state_q != RUN;
    assign done          = done_q;
    assign error         = error_q;
    assign instr_wr_en   = wr_en_q;
    assign instr_in      = wr_data_q;
    assign instr_wr_addr = wr_addr_q;
    // next state: start handling, beat acceptance with 1-cycle registered write, release hold count
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        num_d     = num_q;
        hold_d    = hold_q;
        error_d   = error_q;
        done_d    = 1'b0;
        wr_en_d   = 1'b0;
        wr_data_d = wr_data_q;
        wr_addr_d = wr_addr_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d     = sum_q;
`endif
        if (can_start) begin
            state_d = legal ? LOAD : IDLE;
            error_d = !legal;
            if (legal) begin
                num_d   = num_words;
                count_d = '0;
`ifdef LOADER_CHECKSUM_EN
                sum_d   = '0;
`endif
            end
        end
        if (fire) begin
            wr_en_d   = 1'b1;
            wr_data_d = s_data;
            wr_addr_d = {count_q[LOGSIZE-1:0], 2'b00};
            count_d   = count_q + NW'(1);
`ifdef LOADER_CHECKSUM_EN
            sum_d     = sum_q + s_data;
`endif
            if (count_q == num_q - NW'(1)) begin
                state_d = RELEASE;
                hold_d  = '0;
            end
        end
        if (state_q == RELEASE) begin
            hold_d = hold_q + HW'(1);
            if (hold_q == HW'(RESET_HOLD - 1)) begin
                state_d = RUN;
                done_d  = 1'b1;
            end
        end
    end
    // state and output registers; reset dominates any same-cycle start
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            num_q     <= '0;
            hold_q    <= '0;
            error_q   <= 1'b0;
            done_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            wr_addr_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            num_q     <= num_d;
            hold_q    <= hold_d;
            error_q   <= error_d;
            done_q    <= done_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            wr_addr_q <= wr_addr_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q     <= sum_d;
`endif
        end
    end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed checks of load sequencing, write timing, errors and reset behaviour.
module tb_imem_boot_loader;
    localparam int HOLD = 4;
    logic        clk = 1'b0;
    logic        reset, start, s_valid;
    logic [6:0]  num_words;
    logic [31:0] s_data;
    logic        s_ready, instr_wr_en, core_reset, busy, done, error;
    logic [31:0] instr_in;
    logic [7:0]  instr_wr_addr;
    logic [31:0] beats [8];
    int          checks = 0;
    int          errors = 0;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] checksum;
`endif
    imem_boot_loader dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .num_words(num_words),
        .s_data(s_data),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .instr_in(instr_in),
        .instr_wr_addr(instr_wr_addr),
        .instr_wr_en(instr_wr_en),
        .core_reset(core_reset),
        .busy(busy),
        .done(done),
        .error(error)
`ifdef LOADER_CHECKSUM_EN
        ,
        .checksum(checksum)
`endif
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic run_load(input int n, input bit gaps);
        int idx = 0;
        int cyc = 0;
        logic v;
        start = 1'b1;
        num_words = 7'(n);
        step();
        start = 1'b0;
        chk("ld_ready", s_ready, 1);
        chk("ld_busy", busy, 1);
        chk("ld_creset", core_reset, 1);
        chk("ld_error", error, 0);
        chk("ld_wen0", instr_wr_en, 0);
        while (idx < n && cyc < 4 * n + 10) begin
            v = gaps ? (cyc % 2 == 0) : 1'b1;
            s_valid = v;
            s_data = beats[idx];
            chk("ready", s_ready, 1);
            step();
            chk("wen", instr_wr_en, v);
            if (v) begin
                chk("waddr", instr_wr_addr, idx * 4);
                chk("wdata", instr_in, beats[idx]);
                idx++;
            end
            cyc++;
        end
        s_valid = 1'b0;
        chk("ld_count", idx, n);
        chk("rel_ready", s_ready, 0);
        chk("rel_creset", core_reset, 1);
        chk("rel_busy", busy, 1);
        for (int i = 1; i < HOLD; i++) begin
            step();
            chk("rel_wen", instr_wr_en, 0);
            chk("rel_creset", core_reset, 1);
            chk("rel_done", done, 0);
        end
        step();
        chk("run_done", done, 1);
        chk("run_creset", core_reset, 0);
        chk("run_busy", busy, 0);
        step();
        chk("run_done_off", done, 0);
        chk("run_creset2", core_reset, 0);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
    initial begin
        reset = 1'b1;
        start = 1'b0;
        s_valid = 1'b0;
        num_words = '0;
        s_data = '0;
        step();
        step();
        chk("rst_creset", core_reset, 1);
        chk("rst_ready", s_ready, 0);
        chk("rst_wen", instr_wr_en, 0);
        chk("rst_data", instr_in, 0);
        chk("rst_addr", instr_wr_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        reset = 1'b0;
        step();
        beats[0] = 32'h0000_0013;
        beats[1] = 32'h0010_0093;
        beats[2] = 32'h0020_8113;
        run_load(3, 1'b0);
        beats[0] = 32'hA5A5_0001;
        beats[1] = 32'h5A5A_0002;
        beats[2] = 32'hDEAD_BEEF;
        beats[3] = 32'h1234_5678;
        run_load(4, 1'b1);
        start = 1'b1;
        num_words = 7'd0;
        step();
        start = 1'b0;
        chk("e0_error", error, 1);
        chk("e0_creset", core_reset, 1);
        chk("e0_ready", s_ready, 0);
        chk("e0_wen", instr_wr_en, 0);
        chk("e0_busy", busy, 0);
        start = 1'b1;
        num_words = 7'd65;
        step();
        start = 1'b0;
        chk("e65_error", error, 1);
        chk("e65_ready", s_ready, 0);
        s_valid = 1'b1;
        repeat (2) begin
            step();
            chk("e_wen", instr_wr_en, 0);
            chk("e_creset", core_reset, 1);
        end
        s_valid = 1'b0;
        beats[0] = 32'h0BAD_F00D;
        run_load(1, 1'b0);
        chk("pre_restart_creset", core_reset, 0);
        beats[0] = 32'hCAFE_0005;
        run_load(1, 1'b0);
        start = 1'b1;
        num_words = 7'd5;
        step();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_valid = 1'b1;
            s_data = 32'h100 + i;
            step();
            chk("mid_wen", instr_wr_en, 1);
            chk("mid_addr", instr_wr_addr, i * 4);
        end
        s_data = 32'h102;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mr_wen", instr_wr_en, 0);
        chk("mr_ready", s_ready, 0);
        chk("mr_busy", busy, 0);
        chk("mr_creset", core_reset, 1);
        repeat (3) begin
            step();
            chk("mr_post_wen", instr_wr_en, 0);
            chk("mr_post_ready", s_ready, 0);
        end
        s_valid = 1'b0;
        reset = 1'b1;
        start = 1'b1;
        num_words = 7'd2;
        step();
        reset = 1'b0;
        start = 1'b0;
        chk("rs_ready", s_ready, 0);
        chk("rs_busy", busy, 0);
        step();
        chk("rs_busy2", busy, 0);
`ifdef LOADER_CHECKSUM_EN
        beats[0] = 32'h0000_0001;
        beats[1] = 32'h0000_0002;
        beats[2] = 32'hFFFF_FFFF;
        run_load(3, 1'b0);
        chk("checksum", checksum, 32'h0000_0002);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
